// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// Opcode/aluop encodings and the multdiv sequencing states.
package pipe_pkg;

    localparam int CNT_W_DEF = 16;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_BEX   = 5'b10110;

    localparam logic [4:0] ALU_MULT = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_MD_DONE = 2'd2
    } md_state_e;

    function automatic logic is_muldiv(
        input logic [4:0] opcode,
        input logic [4:0] aluop
    );
        return (opcode == OP_RTYPE) &&
               ((aluop == ALU_MULT) || (aluop == ALU_DIV));
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Decides whether the instruction in X transfers control.
// Purely combinational; comparator flags come from the X-stage ALU.
module branch_resolve
    import pipe_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       valid,
    input  logic       not_equal,
    input  logic       less_than,
    output logic       taken
);

    logic cond;

    always_comb begin
        cond = 1'b0;
        unique case (opcode)
            OP_J, OP_JAL, OP_JR: cond = 1'b1;
            OP_BNE:              cond = not_equal;
            OP_BLT:              cond = less_than;
            OP_BEX:              cond = not_equal;
            default:             cond = 1'b0;
        endcase
    end

    assign taken = valid & cond;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: redirects, load-use bubbles, multdiv freeze.
// Also keeps saturating stall/flush event counters for debug.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       x_opcode,
    input  logic [4:0]       x_aluop,
    input  logic             x_isNotEqual,
    input  logic             x_isLessThan,
    input  logic             x_valid,
    input  logic [4:0]       x_rd,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_valid,
    input  logic             md_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             fd_flush,
    output logic             dx_flush,
    output logic             xm_flush,
    output logic             pc_redirect,
    output logic             md_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TW = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] MD_LAST = TW'(MD_TIMEOUT - 1);

    md_state_e     state;
    md_state_e     state_n;
    logic [TW-1:0] md_cnt;
    logic          taken;
    logic          md_op;
    logic          load_use;
    logic          stall_inc;
    logic          flush_inc;
    logic          err_set;

    branch_resolve u_branch_resolve (
        .opcode    (x_opcode),
        .valid     (x_valid),
        .not_equal (x_isNotEqual),
        .less_than (x_isLessThan),
        .taken     (taken)
    );

    assign md_op = x_valid & is_muldiv(x_opcode, x_aluop);

    assign load_use = x_valid && (x_opcode == OP_LW) && d_valid &&
                      (x_rd != 5'd0) &&
                      ((x_rd == d_rs) || (x_rd == d_rt));

    always_comb begin
        state_n     = state;
        pc_en       = 1'b1;
        fd_en       = 1'b1;
        dx_en       = 1'b1;
        xm_en       = 1'b1;
        fd_flush    = 1'b0;
        dx_flush    = 1'b0;
        xm_flush    = 1'b0;
        pc_redirect = 1'b0;
        md_start    = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        err_set     = 1'b0;
        unique case (state)
            ST_RUN: begin
                // A taken transfer kills the younger load, so it wins
                if (taken) begin
                    pc_redirect = 1'b1;
                    fd_flush    = 1'b1;
                    dx_flush    = 1'b1;
                    flush_inc   = 1'b1;
                end else if (md_op) begin
                    md_start  = 1'b1;
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_en     = 1'b0;
                    xm_flush  = 1'b1;
                    stall_inc = 1'b1;
                    state_n   = ST_MD_BUSY;
                end else if (load_use) begin
                    pc_en     = 1'b0;
                    fd_en     = 1'b0;
                    dx_flush  = 1'b1;
                    stall_inc = 1'b1;
                end
            end
            ST_MD_BUSY: begin
                pc_en     = 1'b0;
                fd_en     = 1'b0;
                dx_en     = 1'b0;
                xm_flush  = 1'b1;
                stall_inc = 1'b1;
                if (md_ready) begin
                    state_n = ST_MD_DONE;
                end else if (md_cnt == MD_LAST) begin
                    err_set = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_MD_DONE: begin
                state_n = ST_RUN;
            end
            default: begin
                state_n = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            md_cnt    <= '0;
            md_error  <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_n;
            if (state != ST_MD_BUSY) begin
                md_cnt <= '0;
            end else begin
                md_cnt <= md_cnt + 1'b1;
            end
            if (err_set) begin
                md_error <= 1'b1;
            end
            if (stall_inc && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush_inc && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed cases plus random
// traffic checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int TO = 8;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clock;
    logic          reset_n;
    logic [4:0]    x_opcode;
    logic [4:0]    x_aluop;
    logic          x_isNotEqual;
    logic          x_isLessThan;
    logic          x_valid;
    logic [4:0]    x_rd;
    logic [4:0]    d_rs;
    logic [4:0]    d_rt;
    logic          d_valid;
    logic          md_ready;
    logic          pc_en;
    logic          fd_en;
    logic          dx_en;
    logic          xm_en;
    logic          fd_flush;
    logic          dx_flush;
    logic          xm_flush;
    logic          pc_redirect;
    logic          md_start;
    logic          md_error;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    typedef struct packed {
        logic          pc_en;
        logic          fd_en;
        logic          dx_en;
        logic          xm_en;
        logic          fd_flush;
        logic          dx_flush;
        logic          xm_flush;
        logic          pc_redirect;
        logic          md_start;
        logic          md_error;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    total;
    int    bad;

    // model: mode 0 = running, 1 = waiting on multdiv, 2 = result cycle
    int m_mode;
    int m_busy;
    bit m_err;
    int m_stall;
    int m_flush;

    logic [4:0] ops [9] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                            5'b00100, 5'b00110, 5'b01000, 5'b10110,
                            5'b00000};

    pipe_hazard_ctrl #(
        .MD_TIMEOUT (TO),
        .CNT_W      (CW)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .x_opcode     (x_opcode),
        .x_aluop      (x_aluop),
        .x_isNotEqual (x_isNotEqual),
        .x_isLessThan (x_isLessThan),
        .x_valid      (x_valid),
        .x_rd         (x_rd),
        .d_rs         (d_rs),
        .d_rt         (d_rt),
        .d_valid      (d_valid),
        .md_ready     (md_ready),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .dx_en        (dx_en),
        .xm_en        (xm_en),
        .fd_flush     (fd_flush),
        .dx_flush     (dx_flush),
        .xm_flush     (xm_flush),
        .pc_redirect  (pc_redirect),
        .md_start     (md_start),
        .md_error     (md_error),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        obs_t  e;
        obs_t  a;
        string nm;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            nm = name_q.pop_front();
            a.pc_en       = pc_en;
            a.fd_en       = fd_en;
            a.dx_en       = dx_en;
            a.xm_en       = xm_en;
            a.fd_flush    = fd_flush;
            a.dx_flush    = dx_flush;
            a.xm_flush    = xm_flush;
            a.pc_redirect = pc_redirect;
            a.md_start    = md_start;
            a.md_error    = md_error;
            a.stall       = stall_cnt;
            a.flush       = flush_cnt;
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got %b want %b", nm, a, e);
            end
        end
    end

    task automatic chk(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    function automatic bit ref_taken();
        if (!x_valid) return 1'b0;
        case (x_opcode)
            5'b00001, 5'b00011, 5'b00100: return 1'b1;
            5'b00010, 5'b10110: return x_isNotEqual;
            5'b00110: return x_isLessThan;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit ref_md();
        return x_valid && x_opcode == 5'b00000 &&
               (x_aluop == 5'b00110 || x_aluop == 5'b00111);
    endfunction

    function automatic bit ref_lu();
        return x_valid && x_opcode == 5'b01000 && d_valid &&
               x_rd != 0 && (x_rd == d_rs || x_rd == d_rt);
    endfunction

    function automatic int sat(int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic clear_in();
        x_opcode = 0; x_aluop = 0; x_isNotEqual = 0;
        x_isLessThan = 0; x_valid = 0; x_rd = 0;
        d_rs = 0; d_rt = 0; d_valid = 0; md_ready = 0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_busy = 0; m_err = 0;
        m_stall = 0; m_flush = 0;
    endtask

    function automatic obs_t base_obs();
        obs_t e;
        e = '0;
        e.pc_en = 1; e.fd_en = 1; e.dx_en = 1; e.xm_en = 1;
        e.md_error = m_err;
        e.stall = CW'(m_stall);
        e.flush = CW'(m_flush);
        return e;
    endfunction

    // Issue one cycle: predict outputs, queue them, advance the model.
    task automatic step(string nm);
        obs_t e;
        int nmode, nbusy, ns, nf;
        bit nerr;
        e = base_obs();
        nmode = m_mode; nbusy = m_busy; nerr = m_err;
        ns = m_stall; nf = m_flush;
        if (m_mode == 0) begin
            if (ref_taken()) begin
                e.pc_redirect = 1; e.fd_flush = 1; e.dx_flush = 1;
                nf = sat(nf + 1);
            end else if (ref_md()) begin
                e.md_start = 1; e.xm_flush = 1;
                e.pc_en = 0; e.fd_en = 0; e.dx_en = 0;
                ns = sat(ns + 1);
                nmode = 1; nbusy = 0;
            end else if (ref_lu()) begin
                e.pc_en = 0; e.fd_en = 0; e.dx_flush = 1;
                ns = sat(ns + 1);
            end
        end else if (m_mode == 1) begin
            e.pc_en = 0; e.fd_en = 0; e.dx_en = 0; e.xm_flush = 1;
            ns = sat(ns + 1);
            nbusy = m_busy + 1;
            if (md_ready) nmode = 2;
            else if (nbusy == TO) begin
                nerr = 1; nmode = 0;
            end
        end else begin
            nmode = 0;
        end
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clock);
        m_mode = nmode; m_busy = nbusy; m_err = nerr;
        m_stall = ns; m_flush = nf;
        #1;
    endtask

    task automatic apply_reset(string nm);
        reset_n = 0;
        clear_in();
        model_reset();
        exp_q.push_back(base_obs());
        name_q.push_back(nm);
        @(posedge clock);
        #1;
        reset_n = 1;
    endtask

    task automatic set_mult();
        clear_in();
        x_valid = 1; x_opcode = 5'b00000; x_aluop = 5'b00110; x_rd = 4;
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_n = 0;
        clear_in();
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        apply_reset("reset");
        step("idle");

        x_valid = 1; x_opcode = 5'b00010; x_isNotEqual = 1;
        step("bne_taken");
        chk("bne_flush_cnt", int'(flush_cnt), 1);

        clear_in();
        x_valid = 1; x_opcode = 5'b00110; x_isLessThan = 0;
        x_isNotEqual = 1;
        step("blt_not_taken");
        chk("blt_flush_cnt", int'(flush_cnt), 1);
        chk("blt_stall_cnt", int'(stall_cnt), 0);

        clear_in();
        x_valid = 1; x_opcode = 5'b01000; x_rd = 5;
        d_valid = 1; d_rs = 5; d_rt = 2;
        step("lw_use");
        chk("lw_use_stall", int'(stall_cnt), 1);
        x_rd = 0; d_rs = 0;
        step("lw_r0");
        chk("lw_r0_stall", int'(stall_cnt), 1);

        apply_reset("reset_md4");
        set_mult();
        step("md4_start");
        for (int i = 0; i < 4; i++) begin
            md_ready = (i == 3);
            step("md4_busy");
        end
        md_ready = 0;
        step("md4_done");
        clear_in();
        step("md4_run");
        chk("md4_stall", int'(stall_cnt), 5);

        apply_reset("reset_to");
        set_mult();
        step("to_start");
        clear_in();
        for (int i = 0; i < TO; i++) step("to_busy");
        chk("to_error", int'(md_error), 1);
        step("to_run");
        md_ready = 1;
        step("to_stray_ready");
        md_ready = 0;
        step("to_sticky");
        chk("to_sticky_err", int'(md_error), 1);

        clear_in();
        x_valid = 1; x_opcode = 5'b00011; x_rd = 3;
        d_valid = 1; d_rs = 3; d_rt = 3;
        step("jal_vs_use");

        set_mult();
        step("rb_start");
        clear_in();
        step("rb_busy");
        step("rb_busy");
        reset_n = 0;
        #1;
        chk("rb_async_stall", int'(stall_cnt), 0);
        chk("rb_async_err", int'(md_error), 0);
        apply_reset("rb_reset");
        step("rb_after");
        step("rb_after");

        for (int i = 0; i < 600; i++) begin
            x_opcode = ops[$urandom_range(0, 8)];
            case ($urandom_range(0, 2))
                0: x_aluop = 5'b00110;
                1: x_aluop = 5'b00111;
                default: x_aluop = 5'($urandom_range(0, 5));
            endcase
            x_valid = ($urandom_range(0, 3) != 0);
            x_isNotEqual = 1'($urandom_range(0, 1));
            x_isLessThan = 1'($urandom_range(0, 1));
            x_rd = 5'($urandom_range(0, 3));
            d_rs = 5'($urandom_range(0, 3));
            d_rt = 5'($urandom_range(0, 3));
            d_valid = 1'($urandom_range(0, 1));
            md_ready = ($urandom_range(0, 5) == 0);
            step("random");
        end

        apply_reset("final_reset");
        chk("final_err_clear", int'(md_error), 0);
        step("final_idle");
        @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
